detector_jogada: RTL
====================

Name: detector_jogada

Overview:
- Parametrised button-capture unit for the game datapath; successor to the fixed 9-button entry path in circuito_jogo.
- Converts NUM_BOTOES raw one-hot buttons into a debounced, validated move index with a single-cycle strobe.
- Rejects presses on occupied cells and multi-button presses, then waits for a debounced release before re-arming.
- Used twice per board: once for the macro selection and once for the micro selection.

Parameters:
- NUM_BOTOES, 9, number of buttons/cells; must be >= 2.
- DEBOUNCE_CICLOS, 4, consecutive stable cycles required for press and for release; must be >= 1.
- IDX_W, $clog2(NUM_BOTOES), width of the move index; derived, not overridden.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (reset=0 resets on the next rising edge).
- habilita  in  1  capture enable; sampled in OCIOSO.
- botoes  in  NUM_BOTOES  raw button levels, bit i = cell i.
- celulas_livres  in  NUM_BOTOES  1 = cell i may be played.
- tem_jogada  out  1  one-cycle strobe for a valid move.
- jogada_idx  out  IDX_W  index of the last valid move; held between strobes.
- jogada_invalida  out  1  one-cycle strobe for a rejected press.
- ocupado  out  1  high in any state other than OCIOSO.
- db_estado  out  3  current state encoding.

Behaviour:
- Reset (reset=0 at an edge): state OCIOSO, counter 0, sample register 0, all outputs 0, jogada_idx=0. Reset has priority over every transition, including mid-filter.
- State OCIOSO (0):
  - If habilita=1 and botoes!=0: latch botoes into amostra, set cnt=1, go to FILTRANDO.
  - Otherwise stay.
- State FILTRANDO (1):
  - If habilita=0: go to ESPERA_SOLTAR (abort; no strobe).
  - Else if botoes!=amostra: treat as bounce, go to OCIOSO, cnt=0.
  - Else if cnt==DEBOUNCE_CICLOS: evaluate amostra.
    - If popcount!=1, go to INVALIDA.
    - Else if celulas_livres[idx]=0, go to INVALIDA.
    - Else register jogada_idx=idx and go to EMITE.
  - Else cnt++.
- State EMITE (2): tem_jogada=1 for exactly this cycle, then go to ESPERA_SOLTAR.
- State INVALIDA (3): jogada_invalida=1 for exactly this cycle; jogada_idx unchanged; then go to ESPERA_SOLTAR.
- State ESPERA_SOLTAR (4):
  - cnt counts consecutive cycles with botoes==0; any nonzero value clears cnt.
  - When cnt reaches DEBOUNCE_CICLOS, go to OCIOSO.
- Latency: with botoes stable from the OCIOSO sampling edge E0, the transition to EMITE occurs at edge E_D (D=DEBOUNCE_CICLOS), so tem_jogada is high between E_D and E_D+1.
- A held button produces exactly one strobe regardless of hold length.
- celulas_livres is sampled only on the evaluation edge.
- tem_jogada and jogada_invalida are never high together. Both are registered outputs.
- cnt width is $clog2(DEBOUNCE_CICLOS+1) and it never wraps.
- Unused encodings 5–7 fall back to OCIOSO on the next edge.

Optional Feature:
- Macro JOGADA_MULTIPLA_PRIORIDADE_EN.
- Defined: a multi-bit amostra selects the lowest set index, which is still subject to the celulas_livres check.
- Undefined: popcount!=1 always gives INVALIDA.

Decomposition:
- Package detector_jogada_pkg holds:
  - state enum: OCIOSO=0, FILTRANDO=1, EMITE=2, INVALIDA=3, ESPERA_SOLTAR=4;
  - the 3-bit state width constant;
  - a function returning the counter width.
- Sub-module codificador_onehot, parametrised by NUM_BOTOES:
  - combinational;
  - outputs idx (lowest set bit), unico (popcount==1) and algum (nonzero).

Test Plan (NUM_BOTOES=9, DEBOUNCE_CICLOS=4, macro undefined unless noted):
- Reset: reset=0 for 1 edge, habilita=1, livres=all 1s, botoes=000001000 held 20 cycles → exactly one tem_jogada pulse 4 edges after the first sample, jogada_idx=3, ocupado until 4 cycles after release.
- Occupied cell: livres bit2=0, botoes=000000100 for 20 cycles → one jogada_invalida pulse, tem_jogada stays 0, jogada_idx stays 3.
- Bounce: botoes alternates 000000010 (2 cycles) / 0 (1 cycle) ×3 → no strobe; then held 10 cycles → tem_jogada once, jogada_idx=1.
- Multi-press: botoes=000010001 for 20 cycles → jogada_invalida once; with JOGADA_MULTIPLA_PRIORIDADE_EN → tem_jogada, jogada_idx=0.
- Enable:
  - habilita=0 during a press → no strobe;
  - habilita rises while the button is still held → capture fires 4 edges later (re-armed from OCIOSO);
  - habilita falls during FILTRANDO → no strobe, state ESPERA_SOLTAR.
- Reset mid-filter: reset=0 for one edge while in FILTRANDO → next cycle db_estado=0, all outputs 0, jogada_idx=0.

Source files
------------

// File: rtl/detector_jogada_pkg.sv
// Shared types for the button-capture unit: state encoding and counter sizing.
package detector_jogada_pkg;

    localparam int ESTADO_W = 3;

    typedef enum logic [ESTADO_W-1:0] {
        OCIOSO        = 3'd0,
        FILTRANDO     = 3'd1,
        EMITE         = 3'd2,
        INVALIDA      = 3'd3,
        ESPERA_SOLTAR = 3'd4
    } estado_t;

    // Counter must hold the value DEBOUNCE_CICLOS itself without wrapping.
    function automatic int largura_cnt(input int debounce);
        return $clog2(debounce + 1);
    endfunction

endpackage

// File: rtl/codificador_onehot.sv
// Combinational encoder: lowest set index, exactly-one-bit flag, any-bit flag.
module codificador_onehot #(
    parameter int NUM_BOTOES = 9,
    localparam int IDX_W = $clog2(NUM_BOTOES)
) (
    input  logic [NUM_BOTOES-1:0] vetor_i,
    output logic [IDX_W-1:0]      idx_o,
    output logic                  unico_o,
    output logic                  algum_o
);

    always_comb begin
        idx_o = '0;
        for (int i = NUM_BOTOES - 1; i >= 0; i--) begin
            if (vetor_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
        algum_o = |vetor_i;
        // Clearing the lowest set bit leaves zero only for a single-bit vector.
        unico_o = algum_o && ((vetor_i & (vetor_i - NUM_BOTOES'(1))) == '0);
    end

endmodule

// File: rtl/detector_jogada.sv
// Debounced, validated button capture producing a one-cycle move strobe.
// Build option JOGADA_MULTIPLA_PRIORIDADE_EN: multi-button press picks the lowest index.
module detector_jogada
    import detector_jogada_pkg::*;
#(
    parameter int NUM_BOTOES      = 9,
    parameter int DEBOUNCE_CICLOS = 4,
    localparam int IDX_W = $clog2(NUM_BOTOES)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  habilita,
    input  logic [NUM_BOTOES-1:0] botoes,
    input  logic [NUM_BOTOES-1:0] celulas_livres,
    output logic                  tem_jogada,
    output logic [IDX_W-1:0]      jogada_idx,
    output logic                  jogada_invalida,
    output logic                  ocupado,
    output logic [ESTADO_W-1:0]   db_estado
);

    localparam int CNT_W = largura_cnt(DEBOUNCE_CICLOS);
    localparam logic [CNT_W-1:0] CNT_FIM   = CNT_W'(DEBOUNCE_CICLOS);
    localparam logic [CNT_W-1:0] CNT_SOLTO = CNT_W'(DEBOUNCE_CICLOS - 1);

`ifdef JOGADA_MULTIPLA_PRIORIDADE_EN
    localparam bit PRIORIDADE = 1'b1;
`else
    localparam bit PRIORIDADE = 1'b0;
`endif

    estado_t                 estado_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic [NUM_BOTOES-1:0]   amostra_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    tem_q;
    logic                    inv_q;

    logic [IDX_W-1:0]        cod_idx;
    logic                    cod_unico;
    logic                    cod_algum;
    logic                    aceita;

    codificador_onehot #(.NUM_BOTOES(NUM_BOTOES)) u_codificador (
        .vetor_i (amostra_q),
        .idx_o   (cod_idx),
        .unico_o (cod_unico),
        .algum_o (cod_algum)
    );

    assign cnt_d  = cnt_q + CNT_W'(1);
    assign aceita = (PRIORIDADE ? cod_algum : cod_unico) && celulas_livres[cod_idx];

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q  <= OCIOSO;
            cnt_q     <= '0;
            amostra_q <= '0;
            idx_q     <= '0;
            tem_q     <= 1'b0;
            inv_q     <= 1'b0;
        end else begin
            tem_q <= 1'b0;
            inv_q <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    if (habilita && (|botoes)) begin
                        amostra_q <= botoes;
                        cnt_q     <= CNT_W'(1);
                        estado_q  <= FILTRANDO;
                    end
                end
                FILTRANDO: begin
                    if (!habilita) begin
                        cnt_q    <= '0;
                        estado_q <= ESPERA_SOLTAR;
                    end else if (botoes != amostra_q) begin
                        cnt_q    <= '0;
                        estado_q <= OCIOSO;
                    end else if (cnt_q == CNT_FIM) begin
                        cnt_q <= '0;
                        if (aceita) begin
                            idx_q    <= cod_idx;
                            tem_q    <= 1'b1;
                            estado_q <= EMITE;
                        end else begin
                            inv_q    <= 1'b1;
                            estado_q <= INVALIDA;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                EMITE, INVALIDA: begin
                    estado_q <= ESPERA_SOLTAR;
                end
                ESPERA_SOLTAR: begin
                    // Release must be seen on DEBOUNCE_CICLOS consecutive edges.
                    if (|botoes) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_SOLTO) begin
                        cnt_q    <= '0;
                        estado_q <= OCIOSO;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    cnt_q    <= '0;
                    estado_q <= OCIOSO;
                end
            endcase
        end
    end

    assign tem_jogada      = tem_q;
    assign jogada_invalida = inv_q;
    assign jogada_idx      = idx_q;
    assign ocupado         = (estado_q != OCIOSO);
    assign db_estado       = estado_q;

endmodule
